// File: rtl/result_fifo_pkg.sv
// Shared ALU-datapath constants and small types used by the result FIFO
// that sits after the shifter stage.
package result_fifo_pkg;

    localparam int RF_DEPTH  = 4;
    localparam int RF_DW     = 4;
    localparam int RF_DROP_W = 4;

    // Per-cycle FIFO operation, decoded from the push/pop qualifiers
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage : result_fifo_pkg

// File: rtl/result_fifo_if.sv
// Handshake bundle between the shifter stage (producer), the result FIFO
// and its consumer.
interface result_fifo_if
    import result_fifo_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int DW    = RF_DW
);

    logic                       in_valid;
    logic [DW-1:0]              O;
    logic                       Cout;
    logic                       in_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [DW-1:0]              out_data;
    logic                       out_cout;
    logic                       out_zero;
    logic [$clog2(DEPTH):0]     count;
    logic [RF_DROP_W-1:0]       drop_cnt;

    // Producer/consumer side of the FIFO
    modport master (
        output in_valid, O, Cout, out_ready,
        input  in_ready, out_valid, out_data, out_cout, out_zero, count, drop_cnt
    );

    // The FIFO itself
    modport slave (
        input  in_valid, O, Cout, out_ready,
        output in_ready, out_valid, out_data, out_cout, out_zero, count, drop_cnt
    );

endinterface : result_fifo_if

// File: rtl/result_fifo.sv
// Result FIFO after the shifter: stores {Cout, O} in arrival order, presents
// the head combinationally and counts results offered while full.
module result_fifo
    import result_fifo_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int DW    = RF_DW
) (
    input  logic            clk,
    input  logic            reset,
    result_fifo_if.slave    bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW:0]            mem [DEPTH];
    logic [AW-1:0]          wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]          rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]          count_reg, count_next;
    logic [RF_DROP_W-1:0]   drop_cnt_reg, drop_cnt_next;

    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic [DW:0]            head;
    fifo_op_e               op;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // in_ready depends only on occupancy, so a full FIFO never accepts even
    // when the head is being popped in the same cycle.
    assign push = bus.in_valid && !full;
    assign pop  = bus.out_ready && !empty;
    assign drop = bus.in_valid && full;

    always_comb begin
        op = OP_IDLE;
        unique case ({pop, push})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        drop_cnt_next = drop_cnt_reg;

        unique case (op)
            OP_PUSH: begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
                count_next  = count_reg + CW'(1);
            end
            OP_POP: begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
                count_next  = count_reg - CW'(1);
            end
            OP_BOTH: begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            default: ;
        endcase

        if (drop && (drop_cnt_reg != '1)) begin
            drop_cnt_next = drop_cnt_reg + RF_DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Storage is intentionally left out of reset; clearing the pointers is
    // enough to discard whatever it holds.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {bus.Cout, bus.O};
        end
    end

    assign head = mem[rd_ptr_reg];

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = head[DW-1:0];
    assign bus.out_cout  = head[DW];
    assign bus.out_zero  = (head[DW-1:0] == '0) && !empty;
    assign bus.count     = count_reg;
    assign bus.drop_cnt  = drop_cnt_reg;

endmodule : result_fifo

// File: tb/tb_result_fifo.sv
// Randomized and directed stimulus for result_fifo, checked against a
// queue-based reference model of the FIFO behaviour.
module tb_result_fifo;

    localparam int DEPTH = 4;
    localparam int DW    = 4;

    logic clk;
    logic reset;

    result_fifo_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

    result_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int txn          = 0;

    logic [DW:0] model_q[$];
    int          model_drops = 0;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (txn %0d, t=%0t)", tag, got, exp, txn, $time);
        end
    endtask

    task automatic check_all();
        logic [DW:0] hd;
        check_val("count",     bus.count,     model_q.size());
        check_val("in_ready",  bus.in_ready,  (model_q.size() != DEPTH) ? 1 : 0);
        check_val("out_valid", bus.out_valid, (model_q.size() != 0) ? 1 : 0);
        check_val("drop_cnt",  bus.drop_cnt,  model_drops);
        if (model_q.size() != 0) begin
            hd = model_q[0];
            check_val("out_data", bus.out_data, hd[DW-1:0]);
            check_val("out_cout", bus.out_cout, hd[DW]);
            check_val("out_zero", bus.out_zero, (hd[DW-1:0] == 0) ? 1 : 0);
        end else begin
            check_val("out_zero_empty", bus.out_zero, 0);
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model,
    // then check the DUT at the following negedge.
    task automatic step(input logic v, input logic [DW-1:0] o, input logic c, input logic rdy);
        int  pre_size;
        bit  do_pop;
        bit  do_push;
        bus.in_valid  = v;
        bus.O         = o;
        bus.Cout      = c;
        bus.out_ready = rdy;
        pre_size = model_q.size();
        do_pop   = rdy && (pre_size != 0);
        do_push  = v && (pre_size != DEPTH);
        if (v && (pre_size == DEPTH) && (model_drops < 15)) model_drops++;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back({c, o});
        txn++;
        $display("txn %0d: in_valid=%0b O=%0h Cout=%0b out_ready=%0b -> model count=%0d drops=%0d",
                 txn, v, o, c, rdy, model_q.size(), model_drops);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_pop();
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic sync_reset_pulse();
        reset = 1'b0;
        model_q.delete();
        model_drops = 0;
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        check_all();
    endtask

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.O         = '0;
        bus.Cout      = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state while held, then after release
        @(negedge clk);
        check_all();
        reset = 1'b1;
        check_all();

        // Single transfer
        step(1'b1, 4'hA, 1'b1, 1'b0);
        idle_pop();

        // Fill to full, drop one offer, drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle_pop();

        // Wrap-around with continuous consumption
        for (int i = 0; i < 10; i++) step(1'b1, DW'(i + 6), DW'(i) % 2 == 0, 1'b1);
        idle_pop();

        // Simultaneous push/pop at count=2, then at full
        step(1'b1, 4'h3, 1'b0, 1'b0);
        step(1'b1, 4'h7, 1'b1, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b1);
        step(1'b1, 4'hB, 1'b1, 1'b0);
        step(1'b1, 4'hC, 1'b0, 1'b0);
        step(1'b1, 4'hD, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) idle_pop();

        // Zero flag
        step(1'b1, 4'h0, 1'b1, 1'b0);
        idle_pop();

        // Drop counter saturation
        for (int i = 0; i < 4; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 4'hF, 1'b1, 1'b0);

        // Reset mid-operation: build count=3 / drop_cnt=2, then assert
        // reset between clock edges and look before the next edge.
        sync_reset_pulse();
        for (int i = 0; i < 4; i++) step(1'b1, DW'(i + 1), 1'b1, 1'b0);
        step(1'b1, 4'h8, 1'b0, 1'b0);
        step(1'b1, 4'h8, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        reset = 1'b0;
        model_q.delete();
        model_drops = 0;
        #1;
        check_val("async_count",     bus.count,     0);
        check_val("async_out_valid", bus.out_valid, 0);
        check_val("async_drop_cnt",  bus.drop_cnt,  0);
        check_val("async_in_ready",  bus.in_ready,  1);
        @(negedge clk);
        reset = 1'b1;
        check_all();
        step(1'b1, 4'h6, 1'b0, 1'b0);
        idle_pop();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 DW'($urandom()),
                 1'($urandom()),
                 1'($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom()),
                 DW'($urandom_range(0, 2)),
                 1'($urandom()),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_result_fifo

// File: doc/result_fifo.md
RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of result entries (power of two, >=2).
REQ-002 SHALL have parameter DW, default 4: result data width, matching the shifter output O.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream result present on O/Cout this cycle.
REQ-006 SHALL have port O  input  DW  shifted ALU result from the shifter stage.
REQ-007 SHALL have port Cout  input  1  ALU carry-out belonging to the same result.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept an entry this cycle.
REQ-009 SHALL have port out_valid  output  1  head entry is valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 SHALL have port out_data  output  DW  head entry result bits.
REQ-012 SHALL have port out_cout  output  1  head entry carry bit.
REQ-013 SHALL have port out_zero  output  1  head entry result equals zero.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port drop_cnt  output  4  saturating count of results offered while full.

Function
REQ-016 SHALL store entries of width DW+1 as {Cout, O}, in order of arrival.
REQ-017 SHALL push when in_valid && in_ready; in_ready = (count != DEPTH), independent of out_ready.
REQ-018 SHALL pop when out_valid && out_ready; out_valid = (count != 0).
REQ-019 SHALL drive out_data/out_cout combinationally from the head entry; out_zero = (out_data == 0) && out_valid.
REQ-020 SHALL have latency of one cycle: an entry pushed at edge N is presented with out_valid=1 after edge N.
REQ-021 SHALL keep write/read pointers log2(DEPTH) bits wide, incremented modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-022 SHALL handle push and pop in the same cycle, neither full nor empty, by leaving count unchanged and advancing both pointers.
REQ-023 SHALL, when empty with in_valid=1 and out_ready=1, only push (no pop, no bypass); count becomes 1.
REQ-024 SHALL, when full with out_ready=1 and in_valid=1, only pop; the offered input is not stored and drop_cnt increments.
REQ-025 SHALL increment drop_cnt by 1 for every cycle with in_valid=1 && in_ready=0, saturating at 15.
REQ-026 SHALL ignore O/Cout when in_valid=0; out_data is don't-care when out_valid=0 except out_zero=0.

Reset
REQ-027 SHALL, on reset low, asynchronously clear the write pointer, read pointer, count and drop_cnt to 0.
REQ-028 SHALL produce during reset and after release: in_ready=1, out_valid=0, out_zero=0, count=0, drop_cnt=0.
REQ-029 SHALL not reset storage contents; a reset mid-operation discards all held entries.
REQ-030 SHALL accept the first push on the first rising edge after reset deassertion.

Structure
REQ-031 SHALL take DEPTH, DW and the drop-counter width from the shared ALU-datapath constants package used by the ALU and shifter.
REQ-032 SHALL be a single module with no sub-modules; it is instantiated in the top level after the shifter, with O/Cout wired in.

Verification
REQ-033 SHALL cover single transfer: reset, push O=4'hA, Cout=1 -> next cycle out_valid=1, out_data=A, out_cout=1, out_zero=0, count=1.
REQ-034 SHALL cover fill to full: 4 pushes of 1,2,3,4 with out_ready=0 -> count=4, in_ready=0; a 5th offer (5) -> drop_cnt=1, then drain yields 1,2,3,4.
REQ-035 SHALL cover wrap-around: 10 pushes with out_ready=1 every cycle -> outputs in order, count stays <=1, pointers wrap, no drops.
REQ-036 SHALL cover simultaneous push/pop at count=2 -> count stays 2; at full with out_ready=1, in_valid=1 -> count=3, drop_cnt+1.
REQ-037 SHALL cover zero flag: push O=0, Cout=1 -> out_zero=1, out_cout=1.
REQ-038 SHALL cover reset mid-operation: at count=3, drop_cnt=2, assert reset asynchronously -> count=0, out_valid=0, drop_cnt=0 immediately, before the next clk edge.
